// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-stage program-counter sequencer.
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ    = 3'd0,
    SEL_BRANCH = 3'd1,
    SEL_JUMP   = 3'd2,
    SEL_CALL   = 3'd3,
    SEL_RET    = 3'd4,
    SEL_TRAP   = 3'd5
  } pc_sel_e;

  localparam int DEFAULT_INSTR_BYTES = 4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-unit side of the PC sequencer: redirect requests in, PC/counters/RAS status out.
// All signals are level-sampled on the rising clock edge; there is no valid/ready handshake.
interface pc_sequencer_if
  import pc_pkg::*;
#(
  parameter int PC_WIDTH  = 16,
  parameter int CNT_WIDTH = 16
) ();

  logic                 stall;
  logic                 branch_en;
  logic [PC_WIDTH-1:0]  branch_offset;
  logic                 jump_en;
  logic                 call_en;
  logic [PC_WIDTH-1:0]  jump_target;
  logic                 ret_en;
  logic                 trap_en;
  logic [PC_WIDTH-1:0]  prog_count;
  logic [CNT_WIDTH-1:0] clock_count;
  logic [CNT_WIDTH-1:0] retire_count;
  logic                 ras_empty;
  logic                 ras_full;
  logic                 ras_overflow;
  logic                 ras_underflow;
  pc_sel_e              sel_dbg;

  modport master (
    output stall, branch_en, branch_offset, jump_en, call_en, jump_target, ret_en, trap_en,
    input  prog_count, clock_count, retire_count, ras_empty, ras_full,
           ras_overflow, ras_underflow, sel_dbg
  );

  modport slave (
    input  stall, branch_en, branch_offset, jump_en, call_en, jump_target, ret_en, trap_en,
    output prog_count, clock_count, retire_count, ras_empty, ras_full,
           ras_overflow, ras_underflow, sel_dbg
  );

endinterface

// File: rtl/pc_return_stack.sv
// Circular return-address stack: a push when full silently overwrites the oldest entry.
module pc_return_stack #(
  parameter int PC_WIDTH  = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                push,
  input  logic                pop,
  input  logic [PC_WIDTH-1:0] push_data,
  output logic [PC_WIDTH-1:0] pop_data,
  output logic                empty,
  output logic                full,
  output logic                overflow,
  output logic                underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [PC_WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    top_idx;
  logic                do_pop, do_push;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(RAS_DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && !pop;
  assign overflow  = do_push && full;
  assign underflow = pop && empty;
  // ptr_q is the next free slot, so the top lives one below it (mod depth).
  assign top_idx   = ptr_q - PTR_W'(1);
  assign pop_data  = mem_q[top_idx];

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (do_pop) begin
      ptr_d   = top_idx;
      count_d = count_q - CNT_W'(1);
    end else if (do_push) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (!full) count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[ptr_q] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC unit: prioritised next-PC select, return-address stack, cycle/retire counters.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                     PC_WIDTH    = 16,
  parameter int                     CNT_WIDTH   = 16,
  parameter int                     INSTR_BYTES = DEFAULT_INSTR_BYTES,
  parameter int                     RAS_DEPTH   = 4,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
  parameter logic [PC_WIDTH-1:0]    TRAP_VECTOR = PC_WIDTH'('h0100)
) (
  input  logic        clock,
  input  logic        reset_n,
  pc_sequencer_if.slave bus
);

  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [CNT_WIDTH-1:0] clk_cnt_q, clk_cnt_d;
  logic [CNT_WIDTH-1:0] ret_cnt_q, ret_cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;

  pc_sel_e              sel;
  logic                 advance;
  logic                 ras_push, ras_pop;
  logic [PC_WIDTH-1:0]  pc_seq, pc_target;
  logic [PC_WIDTH-1:0]  ras_data;
  logic                 ras_empty, ras_full, ras_ovf_pulse, ras_unf_pulse;

  assign pc_seq  = pc_q + PC_WIDTH'(INSTR_BYTES);
  // A trap overrides stall; otherwise a stall freezes PC, RAS and retire count.
  assign advance = bus.trap_en || !bus.stall;

  pc_return_stack #(
    .PC_WIDTH  (PC_WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_seq),
    .pop_data  (ras_data),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_ovf_pulse),
    .underflow (ras_unf_pulse)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= RESET_PC;
      clk_cnt_q <= '0;
      ret_cnt_q <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      clk_cnt_q <= clk_cnt_d;
      ret_cnt_q <= ret_cnt_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  // Next-state: redirect selection and target.
  always_comb begin
    sel = SEL_SEQ;
    if      (bus.trap_en)   sel = SEL_TRAP;
    else if (bus.ret_en)    sel = SEL_RET;
    else if (bus.call_en)   sel = SEL_CALL;
    else if (bus.jump_en)   sel = SEL_JUMP;
    else if (bus.branch_en) sel = SEL_BRANCH;

    pc_target = pc_seq;
    case (sel)
      SEL_TRAP:             pc_target = TRAP_VECTOR;
      SEL_RET:              pc_target = ras_empty ? TRAP_VECTOR : ras_data;
      SEL_CALL, SEL_JUMP:   pc_target = bus.jump_target;
      SEL_BRANCH:           pc_target = pc_seq + bus.branch_offset;
      default:              pc_target = pc_seq;
    endcase

    ras_push  = advance && (sel == SEL_CALL);
    ras_pop   = advance && (sel == SEL_RET);
    pc_d      = advance ? pc_target : pc_q;
    clk_cnt_d = clk_cnt_q + CNT_WIDTH'(1);
    ret_cnt_d = advance ? ret_cnt_q + CNT_WIDTH'(1) : ret_cnt_q;
    ovf_d     = ovf_q || ras_ovf_pulse;
    unf_d     = unf_q || ras_unf_pulse;
  end

  // Outputs.
  always_comb begin
    bus.prog_count    = pc_q;
    bus.clock_count   = clk_cnt_q;
    bus.retire_count  = ret_cnt_q;
    bus.ras_empty     = ras_empty;
    bus.ras_full      = ras_full;
    bus.ras_overflow  = ovf_q;
    bus.ras_underflow = unf_q;
    bus.sel_dbg       = sel;
  end

endmodule
